// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master side (controller/testbench) drives enable and divisor requests;
// the slave side (divider) returns handshake pulses, status and the divided clock.
interface clock_divider_prog_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             div_ack;
  logic             div_err;
  logic [CNT_W-1:0] div_active;
  logic             tick;
  logic             clkout;

  modport master (
    output en, div_in, div_load,
    input  div_ack, div_err, div_active, tick, clkout
  );

  modport slave (
    input  en, div_in, div_load,
    output div_ack, div_err, div_active, tick, clkout
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider (divide-by-N, 2 <= N <= 2**CNT_W-1).
// 50% duty for both odd and even N: a posedge phase register "a" is high for the
// first floor(N/2) counts; for odd N a negedge copy "b" stretches the high phase by
// half an input cycle. Divisor changes and start/stop only land on period
// boundaries so clkout never produces runt pulses (except at asynchronous reset).
module clock_divider_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic                 clkin,
  input  logic                 reset_n,
  clock_divider_prog_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] div_active_q, div_active_d;
  logic             a_q, a_d;
  logic             b_q;
  logic             div_ack_q, div_ack_d;
  logic             div_err_q, div_err_d;
  logic             tick_q, tick_d;

  logic             wrap_s;
  logic             apply_s;
  logic             load_ok_s;
  logic             load_bad_s;
  logic [CNT_W-1:0] half_s;

  // Period boundary, divisor apply condition and load qualification.
  always_comb begin
    wrap_s     = (state_q != ST_IDLE) && (cnt_q == (div_active_q - ONE));
    apply_s    = pend_vld_q && ((state_q == ST_IDLE) || wrap_s);
    load_ok_s  = bus.div_load && (bus.div_in >= TWO);
    load_bad_s = bus.div_load && (bus.div_in < TWO);
  end

  // Run/stop FSM: a stop request lets the current period finish before idling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!bus.en) state_d = ST_STOP;
        else         state_d = ST_RUN;
      end
      ST_STOP: begin
        if (bus.en)      state_d = ST_RUN;
        else if (wrap_s) state_d = ST_IDLE;
        else             state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending/active divisor bookkeeping; a load on the apply edge waits for the next boundary.
  always_comb begin
    div_active_d = div_active_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    if (apply_s) begin
      div_active_d = pend_q;
      pend_vld_d   = 1'b0;
    end else begin
      div_active_d = div_active_q;
    end
    if (load_ok_s) begin
      pend_d     = bus.div_in;
      pend_vld_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
    div_ack_d = apply_s;
    div_err_d = load_bad_s;
  end

  // Counter and phase: next-cycle values use the divisor that will be active next cycle.
  always_comb begin
    half_s = div_active_d >> 1;
    if ((state_q == ST_IDLE) || wrap_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
    if (state_d != ST_IDLE) begin
      a_d    = (cnt_d < half_s);
      tick_d = (cnt_d == (div_active_d - ONE));
    end else begin
      a_d    = 1'b0;
      tick_d = 1'b0;
    end
  end

  // Posedge state registers, all cleared asynchronously.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      div_active_q <= DIV_RST;
      a_q          <= 1'b0;
      div_ack_q    <= 1'b0;
      div_err_q    <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      div_active_q <= div_active_d;
      a_q          <= a_d;
      div_ack_q    <= div_ack_d;
      div_err_q    <= div_err_d;
      tick_q       <= tick_d;
    end
  end

  // Half-cycle delayed copy of the phase, used to stretch the high phase for odd N.
  always_ff @(negedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      b_q <= 1'b0;
    end else begin
      b_q <= a_q;
    end
  end

  // Mode mux only changes at an apply, which coincides with a rising phase, so no glitch.
  assign bus.clkout     = div_active_q[0] ? (a_q | b_q) : a_q;
  assign bus.div_ack    = div_ack_q;
  assign bus.div_err    = div_err_q;
  assign bus.div_active = div_active_q;
  assign bus.tick       = tick_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: a period-position model predicts
// every output on each half cycle; directed sequences pin the model with literals,
// then randomized enable/load traffic exercises boundaries.
module tb_clock_divider_prog;

  localparam int CNT_W = 8;
  localparam int DEF   = 3;

  logic clkin;
  logic reset_n;

  clock_divider_prog_if #(.CNT_W(CNT_W)) bus_if();

  clock_divider_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clkin   (clkin),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;

  // Model: is an output period in progress, position in it, divisor, pending request.
  bit m_active   = 1'b0;
  bit m_stopping = 1'b0;
  int m_pos      = 0;
  int m_n        = DEF;
  int m_pend     = 0;
  bit m_pvld     = 1'b0;
  bit exp_ack    = 1'b0;
  bit exp_err    = 1'b0;
  bit exp_tick   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_stopping = 1'b0; m_pos = 0; m_n = DEF;
    m_pend = 0; m_pvld = 1'b0; exp_ack = 1'b0; exp_err = 1'b0; exp_tick = 1'b0;
  endtask

  task automatic model_step();
    bit wrap;
    wrap    = m_active && (m_pos == m_n - 1);
    exp_err = bus_if.div_load && (bus_if.div_in < 2);
    exp_ack = m_pvld && (!m_active || wrap);
    if (exp_ack) begin
      m_n    = m_pend;
      m_pvld = 1'b0;
    end
    if (!m_active) begin
      if (bus_if.en) begin
        m_active = 1'b1; m_pos = 0; m_stopping = 1'b0;
      end
    end else if (wrap && m_stopping && !bus_if.en) begin
      m_active = 1'b0; m_pos = 0;
    end else begin
      m_pos      = wrap ? 0 : m_pos + 1;
      m_stopping = !bus_if.en;
    end
    if (bus_if.div_load && (bus_if.div_in >= 2)) begin
      m_pend = bus_if.div_in;
      m_pvld = 1'b1;
    end
    exp_tick = m_active && (m_pos == m_n - 1);
  endtask

  // Compare process: clkout is high for the first N half-cycles of each N-cycle period.
  always begin
    @(posedge clkin);
    if (!reset_n) model_reset();
    else          model_step();
    #1;
    if (reset_n) begin
      chk("div_active", bus_if.div_active, m_n);
      chk("div_ack", bus_if.div_ack, exp_ack);
      chk("div_err", bus_if.div_err, exp_err);
      chk("tick", bus_if.tick, exp_tick);
      chk("clkout_hi_phase", bus_if.clkout, (m_active && (2 * m_pos < m_n)) ? 1 : 0);
    end
    @(negedge clkin);
    #1;
    if (reset_n) begin
      chk("clkout_lo_phase", bus_if.clkout, (m_active && (2 * m_pos + 1 < m_n)) ? 1 : 0);
    end
  end

  // All stimulus changes happen 2 time units after a negedge.
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clkin);
    #2;
  endtask

  task automatic sample_halves(input int nh, output int highs, output logic [15:0] first);
    highs = 0;
    first = '0;
    for (int i = 0; i < nh; i++) begin
      if (i % 2 == 0) @(posedge clkin);
      else            @(negedge clkin);
      #1;
      if (bus_if.clkout) highs++;
      if (i < 16) first[i] = bus_if.clkout;
    end
  endtask

  task automatic load_pulse(input int v);
    bus_if.div_in   = v[CNT_W-1:0];
    bus_if.div_load = 1'b1;
    wait_cycles(1);
    bus_if.div_load = 1'b0;
  endtask

  initial begin
    int          highs;
    logic [15:0] first;
    reset_n         = 1'b0;
    bus_if.en       = 1'b0;
    bus_if.div_in   = '0;
    bus_if.div_load = 1'b0;

    // Reset state.
    @(negedge clkin);
    #2;
    chk("rst_clkout", bus_if.clkout, 0);
    chk("rst_div_active", bus_if.div_active, DEF);
    chk("rst_div_ack", bus_if.div_ack, 0);
    chk("rst_div_err", bus_if.div_err, 0);
    chk("rst_tick", bus_if.tick, 0);

    // Default N=3 right after reset: 1.5 high / 1.5 low.
    reset_n   = 1'b1;
    bus_if.en = 1'b1;
    sample_halves(12, highs, first);
    #1;
    chk("n3_pattern", first[11:0], 12'b000111000111);
    chk("n3_highs", highs, 6);

    // Stop, then load 4 while idle.
    bus_if.en = 1'b0;
    wait_cycles(8);
    load_pulse(4);
    wait_cycles(1);
    chk("n4_applied_idle", bus_if.div_active, 4);
    bus_if.en = 1'b1;
    sample_halves(8, highs, first);
    #1;
    chk("n4_pattern", first[7:0], 8'b00001111);
    chk("n4_highs", highs, 4);

    // Load 7 while the counter is at 1 of an N=4 period.
    wait_cycles(2);
    load_pulse(7);
    wait_cycles(30);
    chk("n7_applied", bus_if.div_active, 7);

    // Illegal divisors are flagged and dropped.
    bus_if.div_in   = 8'd1;
    bus_if.div_load = 1'b1;
    wait_cycles(1);
    bus_if.div_in = 8'd0;
    wait_cycles(1);
    bus_if.div_load = 1'b0;
    wait_cycles(10);
    chk("err_keeps_div", bus_if.div_active, 7);

    // N=5 then stop at count 1.
    load_pulse(5);
    wait_cycles(12);
    bus_if.en = 1'b0;
    wait_cycles(12);
    chk("n5_stopped_clkout", bus_if.clkout, 0);
    bus_if.en = 1'b1;
    wait_cycles(10);

    // Reset in the middle of an N=255 period.
    bus_if.en = 1'b0;
    wait_cycles(20);
    load_pulse(255);
    wait_cycles(1);
    bus_if.en = 1'b1;
    wait_cycles(100);
    reset_n = 1'b0;
    #1;
    chk("midrst_clkout", bus_if.clkout, 0);
    chk("midrst_div_active", bus_if.div_active, DEF);
    #1;
    wait_cycles(2);
    reset_n   = 1'b1;
    bus_if.en = 1'b0;
    wait_cycles(1);

    // Full N=255 period: 127.5 cycles high.
    load_pulse(255);
    wait_cycles(1);
    chk("n255_applied", bus_if.div_active, 255);
    bus_if.en = 1'b1;
    sample_halves(510, highs, first);
    #1;
    chk("n255_highs", highs, 255);
    bus_if.en = 1'b0;
    wait_cycles(260);

    // Randomized enable/load traffic.
    bus_if.en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 24) == 0) bus_if.en = ~bus_if.en;
      bus_if.div_load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) bus_if.div_in = 8'(($urandom_range(100, 255)));
      else                            bus_if.div_in = 8'(($urandom_range(0, 11)));
      wait_cycles(1);
    end
    bus_if.div_load = 1'b0;
    bus_if.en       = 1'b0;
    wait_cycles(300);
    chk("final_idle_clkout", bus_if.clkout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
